// File: rtl/mode_counter_pkg.sv
// Shared step constants and the modular step arithmetic used by the counter.
package mode_counter_pkg;

  localparam logic [31:0] STEP_ONE = 32'd1;
  localparam logic [31:0] STEP_TWO = 32'd2;

  // Returns {wrapped, next}; count and step are assumed already below modulus.
  function automatic logic [32:0] f_mod_step(input logic [31:0] count,
                                             input logic [31:0] step,
                                             input logic        up,
                                             input logic [31:0] modulus);
    logic [32:0] s;
    logic [32:0] s_sub;
    logic        wrapped;
    logic [31:0] nxt;
    s     = {1'b0, count} + {1'b0, step};
    s_sub = s - {1'b0, modulus};
    if (modulus == 32'd2 && step == STEP_TWO) begin
      wrapped = 1'b1;
      nxt     = count;
    end else if (up) begin
      wrapped = (s >= {1'b0, modulus});
      nxt     = wrapped ? s_sub[31:0] : s[31:0];
    end else begin
      wrapped = (count < step);
      nxt     = wrapped ? (count + modulus - step) : (count - step);
    end
    return {wrapped, nxt};
  endfunction

endpackage

// File: rtl/mode_counter_next.sv
// Combinational step selection and modular next-value computation.
module mode_counter_next
  import mode_counter_pkg::*;
#(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 2 ** WIDTH
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up,
  input  logic             even,
  input  logic             odd,
  output logic [WIDTH-1:0] next_val,
  output logic             wrapped
);

  logic [31:0] step;
  logic [32:0] res;
  logic        unused_hi;

  always_comb begin
    step = ((!count[0] && even) || (count[0] && odd)) ? STEP_TWO : STEP_ONE;
    res  = f_mod_step(32'(count), step, up, 32'(MODULUS));
  end

  assign next_val  = res[WIDTH-1:0];
  assign wrapped   = res[32];
  assign unused_hi = ^res[31:WIDTH];

endmodule

// File: rtl/mode_counter_param.sv
// Modular up/down counter with parity skip, hold, enable and range-checked load.
module mode_counter_param
  import mode_counter_pkg::*;
#(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 2 ** WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             even,
  input  logic             odd,
  input  logic             hold,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] next_count,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  localparam logic [WIDTH:0] MOD_W = (WIDTH + 1)'(MODULUS);

  if (WIDTH < 1 || WIDTH > 31 || MODULUS < 2 || MODULUS > 2 ** WIDTH) begin : g_bad_params
    $error("mode_counter_param: need 1 <= WIDTH <= 31 and 2 <= MODULUS <= 2**WIDTH");
  end

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             load_err_q, load_err_d;
  logic [WIDTH-1:0] step_val;
  logic             step_wrapped;
  logic             load_ok;

  mode_counter_next #(
    .WIDTH  (WIDTH),
    .MODULUS(MODULUS)
  ) u_next (
    .count   (count_q),
    .up      (up),
    .even    (even),
    .odd     (odd),
    .next_val(step_val),
    .wrapped (step_wrapped)
  );

  // Priority: load > hold > !en > count step.
  always_comb begin
    count_d    = count_q;
    load_err_d = 1'b0;
    load_ok    = ({1'b0, load_val} < MOD_W);
    tc         = !load && !hold && en && step_wrapped;
    if (load) begin
      if (load_ok) count_d = load_val;
      else         load_err_d = 1'b1;
    end else if (!hold && en) begin
      count_d = step_val;
    end
    wrap_d = tc;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q    <= '0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign count      = count_q;
  assign next_count = count_d;
  assign wrap       = wrap_q;
  assign load_err   = load_err_q;

endmodule
